seq_match_monitor: RTL and testbench
====================================

# seq_match_monitor

Downstream stage of the serial sequence detector. It consumes the detector's single-cycle Moore match flag and keeps a saturating match count. It also measures the spacing in cycles between successive matches and raises a level interrupt when a programmable match threshold is reached. Software or a controller clears the interrupt with an acknowledge.

## Interface

Parameters:
- CNT_W, 16, width of the match counter and the threshold
- GAP_W, 8, width of the inter-match gap measurement

Ports:
- clk  input  1  single clock; all logic is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- det  input  1  detector match flag; each high cycle is one match
- enable  input  1  1 = monitor active, 0 = hold all statistics
- clear  input  1  synchronous clear of all statistics
- thresh  input  CNT_W  alert threshold; 0 disables alerts
- irq_ack  input  1  acknowledges the interrupt; honoured only in ALERT
- match_cnt  output  CNT_W  matches since the last clear or ack; saturating
- last_gap  output  GAP_W  cycles between the two most recent matches; saturating
- gap_valid  output  1  high once two matches have been seen since the last clear
- overflow  output  1  sticky; set when match_cnt saturates
- irq  output  1  high while in ALERT

## Operation

- Reset (rst_n=0, asynchronous): state IDLE. match_cnt, last_gap, gap_valid, overflow, irq and the internal gap counter are all 0. The internal seen-first flag is also 0.
- FSM states are IDLE, COUNT and ALERT. irq equals (state==ALERT).
- Transition priority per cycle is clear, then enable, then ack, then det.
  - IDLE: moves to COUNT when enable=1. det is ignored while in IDLE.
  - COUNT: with enable=0, goes to IDLE and holds all statistics. On det, match_cnt increments. If the new value equals thresh and thresh≠0, goes to ALERT.
  - ALERT: det keeps incrementing match_cnt and never re-triggers. On irq_ack, match_cnt becomes (det ? 1 : 0) and the state returns to COUNT. If that new value equals thresh (thresh=1 with det), the state goes straight back to ALERT. enable=0 goes to IDLE, drops irq and holds statistics.
- clear: zeros match_cnt, last_gap, gap_valid, overflow, the gap counter and seen-first. The next state is COUNT if enable=1, else IDLE. det in the clear cycle is ignored.
- Match counter: saturates at 2^CNT_W−1. overflow sets on the cycle the counter would wrap and stays set until clear or reset. irq_ack does not clear overflow.
- Gap measurement, active only in COUNT and ALERT:
  - The gap counter runs only after the first match. It increments every cycle and saturates at 2^GAP_W−1.
  - On each det, if seen-first=1: last_gap becomes gap_counter+1, so matches in adjacent cycles give 1. gap_valid becomes 1 and the gap counter resets to 0.
  - On the first det, seen-first sets and the gap counter resets to 0. last_gap is unchanged.
- thresh is sampled every cycle and is not latched. Lowering thresh below the current match_cnt does not raise irq.

## Timing

- All outputs are registered. det sampled at edge N updates match_cnt, last_gap and gap_valid, visible after edge N.
- irq rises at the same edge at which match_cnt becomes equal to thresh.
- irq_ack sampled at edge N drops irq after edge N.
- det and irq_ack in the same cycle: the ack wins the count reset and that det counts as 1.
- enable rising at edge N: the state is COUNT after edge N, and det is counted from edge N+1.
- Reset mid-operation drops irq immediately and asynchronously.

## Test plan

- Reset, then enable=1, thresh=3, with det pulses at cycles 2, 5 and 8. Required: match_cnt goes 1, 2, 3; irq rises with match_cnt=3; last_gap=3; gap_valid high after the second pulse.
- In ALERT, two more det pulses, then irq_ack together with det. Required: match_cnt goes 4, 5, then 1; irq low after the ack edge; the state is COUNT.
- thresh=0 with 10 det pulses. Required: match_cnt=10 and irq stays 0.
- CNT_W=4, thresh=0, 17 det pulses. Required: match_cnt=15 and overflow=1. After clear, all outputs are 0.
- Matches in adjacent cycles, then 300 idle cycles, then one more det with GAP_W=8. Required: last_gap=1, then last_gap=255.
- With irq high, drive enable=0. Required: irq drops and match_cnt holds. Then assert rst_n=0 mid-stream: every output is 0 without waiting for a clock edge.

Source files
------------

// File: rtl/seq_match_monitor_if.sv
// Bundles the monitor's control inputs and statistics outputs.
// The controller side uses master and the monitor uses slave.
interface seq_match_monitor_if #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
);
    logic             det;
    logic             enable;
    logic             clear;
    logic [CNT_W-1:0] thresh;
    logic             irq_ack;
    logic [CNT_W-1:0] match_cnt;
    logic [GAP_W-1:0] last_gap;
    logic             gap_valid;
    logic             overflow;
    logic             irq;

    modport master (
        output det, enable, clear, thresh, irq_ack,
        input  match_cnt, last_gap, gap_valid, overflow, irq
    );

    modport slave (
        input  det, enable, clear, thresh, irq_ack,
        output match_cnt, last_gap, gap_valid, overflow, irq
    );
endinterface

// File: rtl/seq_match_monitor.sv
// Match statistics monitor behind the serial sequence detector.
// The monitor keeps a saturating match count and measures the gap between successive matches.
// It raises a level interrupt when the count reaches a programmable threshold.
module seq_match_monitor #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_match_monitor_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] ALERT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [GAP_W-1:0] last_gap_reg, last_gap_next;
    logic             gap_valid_reg, gap_valid_next;
    logic             overflow_reg, overflow_next;
    logic             seen_first_reg, seen_first_next;

    // Saturating increments shared by the count and gap paths
    logic [CNT_W-1:0] cnt_inc;
    logic [GAP_W-1:0] gap_inc;
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
    assign gap_inc = (gap_cnt_reg == GAP_MAX) ? gap_cnt_reg : gap_cnt_reg + GAP_ONE;

    // Next-state logic: clear beats enable, enable beats ack, ack beats det
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        last_gap_next   = last_gap_reg;
        gap_valid_next  = gap_valid_reg;
        overflow_next   = overflow_reg;
        seen_first_next = seen_first_reg;

        if (bus.clear) begin
            cnt_next        = '0;
            gap_cnt_next    = '0;
            last_gap_next   = '0;
            gap_valid_next  = 1'b0;
            overflow_next   = 1'b0;
            seen_first_next = 1'b0;
            state_next      = bus.enable ? COUNT : IDLE;
        end else if (!bus.enable) begin
            // Disabled: park in IDLE with every statistic frozen
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = COUNT;
                end
                COUNT: begin
                    if (bus.det) begin
                        cnt_next = cnt_inc;
                        if (cnt_reg == CNT_MAX) begin
                            overflow_next = 1'b1;
                        end
                        if ((cnt_inc == bus.thresh) && (bus.thresh != '0)) begin
                            state_next = ALERT;
                        end
                    end
                end
                ALERT: begin
                    if (bus.irq_ack) begin
                        // A det alongside the ack is the first match of the new window
                        cnt_next   = bus.det ? CNT_ONE : '0;
                        state_next = (bus.det && (bus.thresh == CNT_ONE)) ? ALERT : COUNT;
                    end else if (bus.det) begin
                        cnt_next = cnt_inc;
                        if (cnt_reg == CNT_MAX) begin
                            overflow_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // Gap timing only runs while actively monitoring
            if ((state_reg == COUNT) || (state_reg == ALERT)) begin
                if (bus.det) begin
                    if (seen_first_reg) begin
                        last_gap_next  = gap_inc;
                        gap_valid_next = 1'b1;
                    end
                    seen_first_next = 1'b1;
                    gap_cnt_next    = '0;
                end else if (seen_first_reg) begin
                    gap_cnt_next = gap_inc;
                end
            end
        end
    end

    // State and statistics registers; reset is asynchronous so irq drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            gap_cnt_reg    <= '0;
            last_gap_reg   <= '0;
            gap_valid_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            seen_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            last_gap_reg   <= last_gap_next;
            gap_valid_reg  <= gap_valid_next;
            overflow_reg   <= overflow_next;
            seen_first_reg <= seen_first_next;
        end
    end

    assign bus.match_cnt = cnt_reg;
    assign bus.last_gap  = last_gap_reg;
    assign bus.gap_valid = gap_valid_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.irq       = (state_reg == ALERT);
endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: a 16-bit counter instance and a 4-bit counter instance for saturation.
module tb_seq_match_monitor;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_match_monitor_if #(.CNT_W(16), .GAP_W(8)) bus16 ();
    seq_match_monitor_if #(.CNT_W(4),  .GAP_W(8)) bus4 ();

    seq_match_monitor #(.CNT_W(16), .GAP_W(8)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    seq_match_monitor #(.CNT_W(4), .GAP_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("[%0t] %s obs=%0d exp=%0d", $time, tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; returns on the following falling edge so outputs are stable
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check16(input string tag, input logic [31:0] cnt, input logic [31:0] irq);
        check({tag, ".cnt"}, 32'(bus16.match_cnt), cnt);
        check({tag, ".irq"}, 32'(bus16.irq), irq);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus16.det = 1'b0; bus16.enable = 1'b0; bus16.clear = 1'b0;
        bus16.thresh = '0; bus16.irq_ack = 1'b0;
        bus4.det = 1'b0; bus4.enable = 1'b0; bus4.clear = 1'b0;
        bus4.thresh = '0; bus4.irq_ack = 1'b0;

        #3;
        check("rst.cnt",       32'(bus16.match_cnt), 0);
        check("rst.last_gap",  32'(bus16.last_gap), 0);
        check("rst.gap_valid", 32'(bus16.gap_valid), 0);
        check("rst.overflow",  32'(bus16.overflow), 0);
        check("rst.irq",       32'(bus16.irq), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable rise: det in the same cycle is not counted
        bus16.enable = 1'b1; bus16.thresh = 16'd3; bus16.det = 1'b1;
        tick(1);
        check16("en_rise", 0, 0);
        bus16.det = 1'b0;
        tick(1);

        // Pulses three cycles apart reach the threshold of 3
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("m1", 1, 0);
        check("m1.gap_valid", 32'(bus16.gap_valid), 0);
        tick(2);
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("m2", 2, 0);
        check("m2.last_gap", 32'(bus16.last_gap), 3);
        check("m2.gap_valid", 32'(bus16.gap_valid), 1);
        tick(2);
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("m3", 3, 1);
        check("m3.last_gap", 32'(bus16.last_gap), 3);

        // More matches in ALERT, then ack together with det
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("alert4", 4, 1);
        check("alert4.last_gap", 32'(bus16.last_gap), 1);
        tick(1);
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("alert5", 5, 1);
        tick(1);
        bus16.det = 1'b1; bus16.irq_ack = 1'b1; tick(1);
        bus16.det = 1'b0; bus16.irq_ack = 1'b0;
        check16("ack_det", 1, 0);
        bus16.det = 1'b1; tick(1);
        check16("post_ack2", 2, 0);
        tick(1); bus16.det = 1'b0;
        check16("post_ack3", 3, 1);
        bus16.irq_ack = 1'b1; tick(1);
        check16("ack_nodet", 0, 0);
        bus16.det = 1'b1; tick(1);
        bus16.det = 1'b0; bus16.irq_ack = 1'b0;
        check16("ack_in_count", 1, 0);

        // Clear, then thresh=1 with ack+det re-enters ALERT directly
        bus16.clear = 1'b1; bus16.det = 1'b1; tick(1);
        bus16.clear = 1'b0; bus16.det = 1'b0;
        check16("clr", 0, 0);
        check("clr.last_gap", 32'(bus16.last_gap), 0);
        check("clr.gap_valid", 32'(bus16.gap_valid), 0);
        bus16.thresh = 16'd1;
        bus16.det = 1'b1; tick(1);
        check16("t1_hit", 1, 1);
        bus16.irq_ack = 1'b1; tick(1);
        check16("t1_ack_det", 1, 1);
        bus16.det = 1'b0; tick(1); bus16.irq_ack = 1'b0;
        check16("t1_ack", 0, 0);

        // Lowering thresh below the count does not alert
        bus16.thresh = 16'd3;
        bus16.det = 1'b1; tick(2); bus16.det = 1'b0;
        check16("low_pre", 2, 0);
        bus16.thresh = 16'd1; tick(1);
        check16("low_thresh", 2, 0);
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check16("low_det", 3, 0);

        // thresh=0: ten adjacent matches, then a long idle gap saturates
        bus16.clear = 1'b1; tick(1); bus16.clear = 1'b0;
        bus16.thresh = 16'd0;
        bus16.det = 1'b1; tick(10); bus16.det = 1'b0;
        check16("t0_10", 10, 0);
        check("adj.last_gap", 32'(bus16.last_gap), 1);
        tick(300);
        bus16.det = 1'b1; tick(1); bus16.det = 1'b0;
        check("sat.last_gap", 32'(bus16.last_gap), 255);
        check16("sat.cnt", 11, 0);

        // 4-bit counter saturation and sticky overflow
        bus4.enable = 1'b1; tick(1);
        bus4.det = 1'b1; tick(15);
        check("c4_15.cnt", 32'(bus4.match_cnt), 15);
        check("c4_15.overflow", 32'(bus4.overflow), 0);
        tick(2); bus4.det = 1'b0;
        check("c4_17.cnt", 32'(bus4.match_cnt), 15);
        check("c4_17.overflow", 32'(bus4.overflow), 1);
        check("c4_17.irq", 32'(bus4.irq), 0);
        bus4.clear = 1'b1; tick(1); bus4.clear = 1'b0;
        check("c4_clr.cnt", 32'(bus4.match_cnt), 0);
        check("c4_clr.overflow", 32'(bus4.overflow), 0);
        check("c4_clr.last_gap", 32'(bus4.last_gap), 0);
        check("c4_clr.gap_valid", 32'(bus4.gap_valid), 0);
        bus4.det = 1'b1; tick(17); bus4.det = 1'b0;
        check("c4_ovf2", 32'(bus4.overflow), 1);

        // Disable while alerting drops irq and holds the count
        bus16.clear = 1'b1; tick(1); bus16.clear = 1'b0;
        bus16.thresh = 16'd2;
        bus16.det = 1'b1; tick(2);
        check16("dis_pre", 2, 1);
        bus16.enable = 1'b0; tick(2);
        check16("dis_hold", 2, 0);
        bus16.enable = 1'b1; tick(1);
        check16("reen_idle", 2, 0);
        bus16.det = 1'b0;
        bus16.clear = 1'b1; tick(1); bus16.clear = 1'b0;
        bus16.det = 1'b1; tick(2); bus16.det = 1'b0;
        check16("pre_rst", 2, 1);

        // Asynchronous reset mid-cycle clears everything before any edge
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.cnt",       32'(bus16.match_cnt), 0);
        check("arst.irq",       32'(bus16.irq), 0);
        check("arst.last_gap",  32'(bus16.last_gap), 0);
        check("arst.gap_valid", 32'(bus16.gap_valid), 0);
        check("arst.c4_cnt",    32'(bus4.match_cnt), 0);
        check("arst.c4_ovf",    32'(bus4.overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
